// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared FSM state type and counter-width helper for seq_divider
package Pkg_Global;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter must hold the value N, so it needs clog2(N+1) bits
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int N = 4
) (
    input  logic [N-1:0] rem_in,
    input  logic         dividend_bit,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_out,
    output logic         quotient_bit
);

    logic [N:0] shifted;
    logic [N:0] diff;

    // Partial remainder stays below the divisor, so the shifted value is below
    // 2*divisor and bit N of the N+1-bit difference is a reliable sign bit.
    always_comb begin
        shifted      = {rem_in, dividend_bit};
        diff         = shifted - {1'b0, divisor};
        quotient_bit = ~diff[N];
        rem_out      = diff[N] ? shifted[N-1:0] : diff[N-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential unsigned restoring divider; optional DIV_ZERO_CHECK_EN adds div_by_zero
module seq_divider
    import Pkg_Global::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
`ifdef DIV_ZERO_CHECK_EN
    output logic         div_by_zero,
`endif
    output logic         busy,
    output logic         done
);

    localparam int CW = cnt_width(N);

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic [N-1:0]  rem_r;
    logic [N-1:0]  dvd_r;
    logic [N-1:0]  dvs_r;
    logic [N-1:0]  step_rem;
    logic          step_q;
    logic [N:0]    q_shift;
    logic          last_step;
    logic          zero_div;

    div_step #(.N(N)) u_step (
        .rem_in       (rem_r),
        .dividend_bit (dvd_r[N-1]),
        .divisor      (dvs_r),
        .rem_out      (step_rem),
        .quotient_bit (step_q)
    );

    // Dividend register doubles as the quotient: bits leave at the top, quotient bits enter at the bottom
    assign q_shift   = {dvd_r, step_q};
    assign last_step = (cnt == CW'(1));

`ifdef DIV_ZERO_CHECK_EN
    assign zero_div = (divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = zero_div ? DONE : CALC;
            CALC:    if (last_step) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            rem_r     <= '0;
            dvd_r     <= '0;
            dvs_r     <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_ZERO_CHECK_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (zero_div) begin
                            quotient  <= '1;
                            remainder <= dividend;
`ifdef DIV_ZERO_CHECK_EN
                            div_by_zero <= 1'b1;
`endif
                        end else begin
                            dvd_r <= dividend;
                            dvs_r <= divisor;
                            rem_r <= '0;
                            cnt   <= CW'(N);
                        end
                    end
                end
                CALC: begin
                    rem_r <= step_rem;
                    dvd_r <= q_shift[N-1:0];
                    cnt   <= cnt - CW'(1);
                    if (last_step) begin
                        quotient  <= q_shift[N-1:0];
                        remainder <= step_rem;
`ifdef DIV_ZERO_CHECK_EN
                        div_by_zero <= 1'b0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule
